// File: rtl/sdfm_filter_array.sv
// sdfm_filter_array: N-channel sigma-delta decimation filter array.
// Each channel synchronises its modulator clock and data into SYSCLK and runs
// a sinc1/2/3 CIC decimator. Each channel has its own ratio and output shift.
// Results are merged round-robin into one tagged show-ahead FIFO.
//
// Ports:
//   SYSCLK, SYSRST          system clock, synchronous active-high reset
//   DSDIN[NCH], SDCLK[NCH]  modulator bitstreams and their (async) clocks
//   cfg_en/order/dec/shift  per-channel enable and settings (latched on enable)
//   cfg_irq_lvl             FIFO level IRQ threshold, 0 disables level term
//   rd_en                   pop FIFO head
//   rd_data, rd_ch          FIFO head result and channel tag
//   fifo_empty, fifo_level  FIFO status
//   ovf, ovf_clr            sticky per-channel result-lost flags, W1C
//   irq                     level or overflow interrupt
module sdfm_filter_array #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned DEC_W      = 8,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   SYSCLK,
    input  logic                   SYSRST,
    input  logic [NCH-1:0]         DSDIN,
    input  logic [NCH-1:0]         SDCLK,
    input  logic [NCH-1:0]         cfg_en,
    input  logic [2*NCH-1:0]       cfg_order,
    input  logic [DEC_W*NCH-1:0]   cfg_dec,
    input  logic [5*NCH-1:0]       cfg_shift,
    input  logic [LVL_W-1:0]       cfg_irq_lvl,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic [CH_W-1:0]        rd_ch,
    output logic                   fifo_empty,
    output logic [LVL_W-1:0]       fifo_level,
    output logic [NCH-1:0]         ovf,
    input  logic [NCH-1:0]         ovf_clr,
    output logic                   irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    logic [NCH-1:0]    req;
    logic [NCH-1:0]    grant;
    logic [NCH-1:0]    ovf_set;
    logic [DATA_W-1:0] hold [NCH];

    // ------------------------------------------------------------------
    // Per-channel sampling, CIC decimator and holding register
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [2:0]        sck_sync;
        logic [1:0]        din_sync;
        logic              en_q;
        logic [1:0]        order_sh;
        logic [DEC_W-1:0]  dec_sh;
        logic [4:0]        shift_sh;
        logic [ACC_W-1:0]  i1, i2, i3;
        logic [ACC_W-1:0]  d1, d2, d3;
        logic [DEC_W-1:0]  cnt;
        logic [1:0]        warm;
        logic              dec_evt;
        logic              pend_r;
        logic [DATA_W-1:0] hold_r;
        logic              run;
        logic              strobe;
        logic              load;
        logic [1:0]        n_skip;
        logic [ACC_W-1:0]  i1_n, i2_n, i3_n;
        logic [ACC_W-1:0]  c0, c1, c2, c3;
        logic [ACC_W-1:0]  comb_out;
        logic [ACC_W-1:0]  shifted;
        logic [DATA_W-1:0] scaled;

        // Channel only runs once the shadows have been captured (cycle after enable rise)
        assign run    = cfg_en[g] & en_q;
        assign strobe = sck_sync[1] & ~sck_sync[2];
        assign load   = run & dec_evt & (warm == n_skip);

        // Integrator next values, comb chain and output scaling
        always_comb begin
            n_skip   = 2'd2;
            c0       = i3;
            comb_out = '0;
            i1_n     = i1 + ACC_W'(din_sync[1]);
            i2_n     = i2 + i1_n;
            i3_n     = i3 + i2_n;
            case (order_sh)
                2'd0:    begin n_skip = 2'd0; c0 = i1; end
                2'd1:    begin n_skip = 2'd1; c0 = i2; end
                default: begin n_skip = 2'd2; c0 = i3; end
            endcase
            c1 = c0 - d1;
            c2 = c1 - d2;
            c3 = c2 - d3;
            case (order_sh)
                2'd0:    comb_out = c1;
                2'd1:    comb_out = c2;
                default: comb_out = c3;
            endcase
            shifted = comb_out >> shift_sh;
            // Unsigned saturation: any bit above DATA_W forces all-ones
            if ((shifted >> DATA_W) != '0) begin
                scaled = '1;
            end else begin
                scaled = shifted[DATA_W-1:0];
            end
        end

        // Synchronisers, config shadows, integrators, decimation and combs
        always_ff @(posedge SYSCLK) begin
            if (SYSRST) begin
                sck_sync <= '0;
                din_sync <= '0;
                en_q     <= 1'b0;
                order_sh <= '0;
                dec_sh   <= '0;
                shift_sh <= '0;
                i1       <= '0;
                i2       <= '0;
                i3       <= '0;
                d1       <= '0;
                d2       <= '0;
                d3       <= '0;
                cnt      <= '0;
                warm     <= '0;
                dec_evt  <= 1'b0;
            end else begin
                sck_sync <= {sck_sync[1:0], SDCLK[g]};
                din_sync <= {din_sync[0], DSDIN[g]};
                en_q     <= cfg_en[g];
                if (cfg_en[g] && !en_q) begin
                    order_sh <= cfg_order[2*g +: 2];
                    dec_sh   <= cfg_dec[DEC_W*g +: DEC_W];
                    shift_sh <= cfg_shift[5*g +: 5];
                end
                if (!run) begin
                    i1      <= '0;
                    i2      <= '0;
                    i3      <= '0;
                    d1      <= '0;
                    d2      <= '0;
                    d3      <= '0;
                    cnt     <= '0;
                    warm    <= '0;
                    dec_evt <= 1'b0;
                end else begin
                    dec_evt <= strobe && (cnt == dec_sh);
                    if (strobe) begin
                        i1  <= i1_n;
                        i2  <= i2_n;
                        i3  <= i3_n;
                        cnt <= (cnt == dec_sh) ? '0 : cnt + DEC_W'(1);
                    end
                    if (dec_evt) begin
                        d1 <= c0;
                        d2 <= c1;
                        d3 <= c2;
                        if (warm != n_skip) begin
                            warm <= warm + 2'd1;
                        end
                    end
                end
            end
        end

        // Holding register; a load in the grant cycle replaces the value being pushed
        always_ff @(posedge SYSCLK) begin
            if (SYSRST) begin
                pend_r <= 1'b0;
                hold_r <= '0;
            end else if (!cfg_en[g]) begin
                pend_r <= 1'b0;
            end else if (load) begin
                pend_r <= 1'b1;
                hold_r <= scaled;
            end else if (grant[g]) begin
                pend_r <= 1'b0;
            end
        end

        assign req[g]     = pend_r & cfg_en[g];
        assign ovf_set[g] = load & pend_r & ~grant[g];
        assign hold[g]    = hold_r;
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter and output FIFO
    // ------------------------------------------------------------------
    fifo_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CH_W-1:0]   last;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic              push;
    logic              pop;
    logic              full;
    logic [LVL_W-1:0]  level_nxt;
    fifo_entry_t       entry;

    assign full = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop  = rd_en & ~fifo_empty;

    // Search starts one past the last granted channel; a pop frees a slot when full
    always_comb begin
        int unsigned idx;
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = (32'(last) + k) % NCH;
            if (!gnt_any && req[CH_W'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(idx);
            end
        end
        push = gnt_any && (!full || rd_en);
        if (push) begin
            grant[gnt_idx] = 1'b1;
        end
        entry.ch   = gnt_idx;
        entry.data = hold[gnt_idx];
        level_nxt  = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + LVL_W'(1);
        end else if (!push && pop) begin
            level_nxt = fifo_level - LVL_W'(1);
        end
    end

    // FIFO storage, pointers, status, overflow flags and interrupt
    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last       <= CH_W'(NCH - 1);
            fifo_level <= '0;
            fifo_empty <= 1'b1;
            ovf        <= '0;
            irq        <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                last        <= gnt_idx;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= level_nxt;
            fifo_empty <= (level_nxt == '0);
            ovf        <= (ovf & ~ovf_clr) | ovf_set;
            irq        <= ((cfg_irq_lvl != '0) && (fifo_level >= cfg_irq_lvl)) || (|ovf);
        end
    end

    assign rd_data = mem[rd_ptr].data;
    assign rd_ch   = mem[rd_ptr].ch;

endmodule

// File: tb/tb_sdfm_filter_array.sv
// Self-checking bench for sdfm_filter_array: table of single-channel filter
// cases plus hand-written sequences for arbitration, overflow, re-enable and reset.
module tb_sdfm_filter_array;

    localparam int unsigned NCH   = 4;
    localparam int unsigned DEC_W = 8;

    logic         SYSCLK = 1'b0;
    logic         SYSRST;
    logic [3:0]   DSDIN;
    logic [3:0]   SDCLK;
    logic [3:0]   cfg_en;
    logic [7:0]   cfg_order;
    logic [31:0]  cfg_dec;
    logic [19:0]  cfg_shift;
    logic [3:0]   cfg_irq_lvl;
    logic         rd_en;
    logic [15:0]  rd_data;
    logic [1:0]   rd_ch;
    logic         fifo_empty;
    logic [3:0]   fifo_level;
    logic [3:0]   ovf;
    logic [3:0]   ovf_clr;
    logic         irq;

    sdfm_filter_array dut (
        .SYSCLK      (SYSCLK),
        .SYSRST      (SYSRST),
        .DSDIN       (DSDIN),
        .SDCLK       (SDCLK),
        .cfg_en      (cfg_en),
        .cfg_order   (cfg_order),
        .cfg_dec     (cfg_dec),
        .cfg_shift   (cfg_shift),
        .cfg_irq_lvl (cfg_irq_lvl),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_ch       (rd_ch),
        .fifo_empty  (fifo_empty),
        .fifo_level  (fifo_level),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr),
        .irq         (irq)
    );

    initial forever #5 SYSCLK = ~SYSCLK;

    // Modulator model: SDCLK = SYSCLK/8 while run[c]; DSDIN changes only in the low phase
    logic [3:0] run = '0;
    logic [3:0] alt = '0;
    int         edges [4];
    int         ph [4];

    initial begin
        SDCLK = '0;
        DSDIN = '0;
        forever begin
            @(negedge SYSCLK);
            for (int c = 0; c < 4; c++) begin
                if (!run[c]) begin
                    ph[c]    = 0;
                    edges[c] = 0;
                    SDCLK[c] = 1'b0;
                    DSDIN[c] = 1'b0;
                end else begin
                    ph[c] = (ph[c] + 1) % 8;
                    if (ph[c] == 4) begin
                        SDCLK[c] = 1'b1;
                        edges[c] = edges[c] + 1;
                    end
                    if (ph[c] == 0) SDCLK[c] = 1'b0;
                    if (ph[c] < 4) DSDIN[c] = alt[c] ? ((edges[c] % 2) == 0) : 1'b1;
                end
            end
        end
    end

    typedef struct {
        int ch;
        int order;
        int dec;
        int shift;
        bit alt;
        int nout;
        int exp_val;
        int exp_first;
    } vec_t;

    typedef struct {
        int ch;
        int data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait for a FIFO entry, compare the head to the scoreboard front, then pop it
    task automatic pop_one(input int budget, input int ech, output int e);
        exp_t x;
        int   n;
        n = 0;
        while (fifo_empty && n < budget) begin
            @(negedge SYSCLK);
            n++;
        end
        e = edges[ech];
        x = sb.pop_front();
        if (fifo_empty) begin
            tests++;
            fails++;
            $display("FAIL pop_timeout: fifo empty after %0d cycles, expected ch%0d=%0d", budget, x.ch, x.data);
        end else begin
            check("rd_ch", rd_ch, x.ch);
            check("rd_data", rd_data, x.data);
            rd_en = 1'b1;
            @(negedge SYSCLK);
            rd_en = 1'b0;
        end
    endtask

    task automatic wait_level(input int t, input int budget);
        int n;
        n = 0;
        while (fifo_level != 4'(t) && n < budget) begin
            @(negedge SYSCLK);
            n++;
        end
        check("level_reach", fifo_level, t);
    endtask

    task automatic do_reset();
        run         = '0;
        cfg_en      = '0;
        rd_en       = 1'b0;
        ovf_clr     = '0;
        cfg_irq_lvl = '0;
        SYSRST      = 1'b1;
        repeat (2) @(negedge SYSCLK);
        SYSRST      = 1'b0;
        @(negedge SYSCLK);
    endtask

    task automatic setup_ch(input int ch, input int order, input int dec, input int shift);
        cfg_order[2*ch +: 2]     = 2'(order);
        cfg_dec[DEC_W*ch +: DEC_W] = 8'(dec);
        cfg_shift[5*ch +: 5]     = 5'(shift);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_ch"}, rd_ch, 0);
        check({tag, "_empty"}, fifo_empty, 1);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_ovf"}, ovf, 0);
        check({tag, "_irq"}, irq, 0);
    endtask

    initial begin
        vec_t vecs [8];
        int   e;
        int   n;

        vecs[0] = '{0, 0,   3, 0, 1'b0, 4,     4,   4};
        vecs[1] = '{1, 2,  15, 0, 1'b0, 3,  4096,  48};
        vecs[2] = '{2, 1, 255, 0, 1'b0, 2, 65535, 512};
        vecs[3] = '{2, 1, 255, 1, 1'b0, 2, 32768, 512};
        vecs[4] = '{3, 2,   7, 0, 1'b1, 4,   256,  24};
        vecs[5] = '{0, 3,   1, 2, 1'b0, 3,     2,   6};
        vecs[6] = '{3, 0,   0, 0, 1'b0, 4,     1,   1};
        vecs[7] = '{1, 2, 255, 9, 1'b0, 2, 32768, 768};

        rd_en       = 1'b0;
        cfg_en      = '0;
        cfg_order   = '0;
        cfg_dec     = '0;
        cfg_shift   = '0;
        cfg_irq_lvl = '0;
        ovf_clr     = '0;
        SYSRST      = 1'b1;
        repeat (3) @(negedge SYSCLK);
        check_reset_outputs("reset");
        SYSRST = 1'b0;

        // Single-channel filter cases; shadows must ignore config changes while enabled
        for (int v = 0; v < 8; v++) begin
            do_reset();
            setup_ch(vecs[v].ch, vecs[v].order, vecs[v].dec, vecs[v].shift);
            cfg_en[vecs[v].ch] = 1'b1;
            repeat (2) @(negedge SYSCLK);
            alt[vecs[v].ch] = vecs[v].alt;
            run[vecs[v].ch] = 1'b1;
            setup_ch(vecs[v].ch, vecs[v].order ^ 1, ~vecs[v].dec, 31);
            for (int k = 0; k < vecs[v].nout; k++) begin
                sb.push_back('{vecs[v].ch, vecs[v].exp_val});
                pop_one((vecs[v].exp_first + 4) * 8 + 200, vecs[v].ch, e);
                if (k == 0) check("first_out_edges", e, vecs[v].exp_first);
            end
        end

        // Four identical channels started together: rotation order and level irq
        do_reset();
        for (int c = 0; c < 4; c++) setup_ch(c, 0, 3, 0);
        cfg_irq_lvl = 4'd4;
        cfg_en      = 4'hF;
        repeat (2) @(negedge SYSCLK);
        alt = '0;
        run = 4'hF;
        for (int r = 0; r < 2; r++) begin
            wait_level(4, 400);
            check("irq_same_cycle_as_level", irq, 0);
            @(negedge SYSCLK);
            check("irq_after_level", irq, 1);
            for (int c = 0; c < 4; c++) sb.push_back('{c, 4});
            for (int c = 0; c < 4; c++) pop_one(16, c, e);
        end

        // Overflow at full FIFO, pop+push at full, W1C clear, pending drop on disable
        do_reset();
        setup_ch(0, 0, 0, 0);
        cfg_en[0] = 1'b1;
        repeat (2) @(negedge SYSCLK);
        run[0] = 1'b1;
        n = 0;
        while (!ovf[0] && n < 400) begin
            @(negedge SYSCLK);
            n++;
        end
        check("ovf_set", ovf, 1);
        check("full_level", fifo_level, 8);
        check("irq_lvl_disabled", irq, 0);
        @(negedge SYSCLK);
        check("irq_from_ovf", irq, 1);
        sb.push_back('{0, 1});
        pop_one(16, 0, e);
        check("level_pop_push_full", fifo_level, 8);
        ovf_clr = 4'b0001;
        @(negedge SYSCLK);
        ovf_clr = '0;
        check("ovf_cleared", ovf, 0);
        check("irq_lag", irq, 1);
        @(negedge SYSCLK);
        check("irq_dropped", irq, 0);
        cfg_en[0] = 1'b0;
        run[0]    = 1'b0;
        repeat (3) @(negedge SYSCLK);
        for (int k = 0; k < 8; k++) sb.push_back('{0, 1});
        for (int k = 0; k < 8; k++) pop_one(16, 0, e);
        check("drained_empty", fifo_empty, 1);
        check("drained_level", fifo_level, 0);
        rd_en = 1'b1;
        @(negedge SYSCLK);
        rd_en = 1'b0;
        check("empty_pop_level", fifo_level, 0);
        check("empty_pop_empty", fifo_empty, 1);
        check("empty_pop_data", rd_data, 1);
        check("empty_pop_ch", rd_ch, 0);

        // Alternating input sinc3, disable mid-frame, re-enable repeats warm-up
        do_reset();
        setup_ch(3, 2, 7, 0);
        cfg_en[3] = 1'b1;
        repeat (2) @(negedge SYSCLK);
        alt[3] = 1'b1;
        run[3] = 1'b1;
        sb.push_back('{3, 256});
        pop_one(500, 3, e);
        check("alt_first_edges", e, 24);
        repeat (30) @(negedge SYSCLK);
        cfg_en[3] = 1'b0;
        run[3]    = 1'b0;
        repeat (4) @(negedge SYSCLK);
        check("no_stale_after_disable", fifo_empty, 1);
        cfg_en[3] = 1'b1;
        repeat (2) @(negedge SYSCLK);
        run[3] = 1'b1;
        sb.push_back('{3, 256});
        pop_one(500, 3, e);
        check("rewarm_edges", e, 24);
        sb.push_back('{3, 256});
        pop_one(200, 3, e);

        // Reset in the middle of an overflowing run
        do_reset();
        setup_ch(0, 0, 0, 0);
        cfg_irq_lvl = 4'd2;
        cfg_en[0]   = 1'b1;
        repeat (2) @(negedge SYSCLK);
        run[0] = 1'b1;
        n = 0;
        while (!ovf[0] && n < 400) begin
            @(negedge SYSCLK);
            n++;
        end
        @(negedge SYSCLK);
        check("pre_reset_irq", irq, 1);
        SYSRST = 1'b1;
        @(negedge SYSCLK);
        check_reset_outputs("midrun_reset");
        SYSRST = 1'b0;
        run    = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge SYSCLK);
        $display("FAIL watchdog: cycle limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
